// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the requester state encoding.
// Used by the master bridge and the APB slave memory.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Wait counter width; a disabled timeout (0) still gets one bit.
    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter. Pulses expired on the enabled cycle whose
// increment brings the count to TIMEOUT; TIMEOUT=0 never expires.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && (cnt != CNT_MAX))
            cnt <= cnt + 1'b1;
    end

    assign expired = (TIMEOUT != 0) && en && (cnt == CNT_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB3 requester. One transfer in flight,
// one response per command, PREADY wait states bounded by TIMEOUT.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    apb_state_e        state_q, state_d;
    logic              psel_d, penable_d, pwrite_d, rsp_err_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;
    logic              tmr_clr, tmr_en, tmr_expired;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);

    always_comb begin
        state_d     = state_q;
        psel_d      = PSEL;
        penable_d   = PENABLE;
        pwrite_d    = PWRITE;
        paddr_d     = PADDR;
        pwdata_d    = PWDATA;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    tmr_clr   = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_rdata_d = PWRITE ? '0 : PRDATA;
                    rsp_err_d   = 1'b0;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    tmr_en = 1'b1;
                    // Abort on the wait cycle that reaches the limit.
                    if (tmr_expired) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            PWRITE    <= pwrite_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: a wait-state APB slave memory plus
// a reference model predicting each response's data, error flag and latency.
module tb_apb_master_bridge;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL, PENABLE, PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA = '0;
    logic              PREADY = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    int          slv_waits = 0;
    int          acc_cnt = 0;
    logic [31:0] smem    [16];
    logic [31:0] ref_mem [16];

    apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    function automatic logic [31:0] pat(input int i);
        return 32'hA500_0000 | (i * 32'h0000_0101);
    endfunction

    // Slave: PREADY after slv_waits ACCESS cycles; junk on PREADY/PRDATA otherwise.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            PREADY  <= (acc_cnt >= slv_waits);
            PRDATA  <= smem[PADDR[5:2]];
            acc_cnt <= acc_cnt + 1;
        end else begin
            PREADY  <= 1'($urandom_range(0, 1));
            PRDATA  <= $urandom;
            acc_cnt <= 0;
        end
    end

    always @(posedge PCLK) begin
        if (!PRESETn) begin
            for (int i = 0; i < 16; i++) smem[i] <= pat(i);
        end else if (PSEL && PENABLE && PREADY && PWRITE) begin
            smem[PADDR[5:2]] <= PWDATA;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic ref_init();
        for (int i = 0; i < 16; i++) ref_mem[i] = pat(i);
    endtask

    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input int rdly, input bit hold);
        int          exp_lat;
        logic [31:0] exp_rd;
        logic        exp_err;
        bit          got;
        if (TIMEOUT != 0 && waits >= TIMEOUT) begin
            exp_lat = 2 + TIMEOUT;
            exp_rd  = '0;
            exp_err = 1'b1;
        end else begin
            exp_lat = 3 + waits;
            exp_err = 1'b0;
            exp_rd  = wr ? 32'h0 : ref_mem[a[5:2]];
            if (wr) ref_mem[a[5:2]] = wd;
        end
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
        slv_waits = waits;
        chk("cmd_ready_idle", cmd_ready, 1);
        chk("psel_idle", PSEL, 0);
        @(posedge PCLK);
        #1;
        if (!hold) begin
            cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
            cmd_write = 1'($urandom_range(0, 1));
        end
        got = 0;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                got = 1;
                chk("latency", k, exp_lat);
                chk("rsp_rdata", rsp_rdata, exp_rd);
                chk("rsp_err", rsp_err, exp_err);
                chk("psel_resp", PSEL, 0);
                chk("penable_resp", PENABLE, 0);
            end else begin
                chk("psel_busy", PSEL, 1);
                chk("penable_phase", PENABLE, (k >= 2));
                chk("paddr", PADDR, a);
                chk("pwrite", PWRITE, wr);
                if (wr) chk("pwdata", PWDATA, wd);
                chk("cmd_ready_busy", cmd_ready, 0);
            end
        end
        chk("rsp_seen", got, 1);
        if (!got) return;
        for (int d = 0; d < rdly; d++) begin
            @(negedge PCLK);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", rsp_err, exp_err);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_psel", PSEL, 0);
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(posedge PCLK);
        #1 rsp_ready = 1'b0;
        @(negedge PCLK);
        chk("rsp_done", rsp_valid, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          r, w;
        ref_init();
        repeat (3) @(negedge PCLK);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_err", rsp_err, 0);

        xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        xfer(1'b0, 32'h10, 32'h0, 0, 0, 0);
        xfer(1'b0, 32'h10, 32'h0, 3, 0, 0);
        xfer(1'b0, 32'h14, 32'h0, 1000, 0, 0);
        xfer(1'b0, 32'h10, 32'h0, 0, 0, 0);
        xfer(1'b1, 32'h20, 32'h1234_5678, 0, 5, 1);
        xfer(1'b0, 32'h20, 32'h0, TIMEOUT - 1, 1, 0);
        xfer(1'b1, 32'h24, 32'hCAFE_F00D, TIMEOUT, 2, 1);
        xfer(1'b0, 32'h24, 32'h0, 1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            r = $urandom_range(0, 9);
            w = (r < 6) ? $urandom_range(0, 3) : (r < 8) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1) : 0;
            xfer(1'($urandom_range(0, 1)), a, $urandom, w, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a stalled ACCESS phase.
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'h5555_AAAA;
        slv_waits = 1000;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge PCLK);
        chk("pre_rst_penable", PENABLE, 1);
        PRESETn = 1'b0;
        #1;
        chk("mid_rst_psel", PSEL, 0);
        chk("mid_rst_penable", PENABLE, 0);
        chk("mid_rst_pwrite", PWRITE, 0);
        chk("mid_rst_paddr", PADDR, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        ref_init();
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_psel", PSEL, 0);
        xfer(1'b0, 32'h8, 32'h0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Upstream APB requester that converts a simple valid/ready command stream into APB3-style transfers (PSEL/PENABLE/PADDR/PWRITE/PWDATA) toward the APB slave memory. It sits between the system-side command source and the APB bus. It returns one response per command with read data and an error flag. A PREADY wait-state timeout keeps the bus from hanging.

## Interface
- ADDR_W, 32, address width (PADDR, cmd_addr)
- DATA_W, 32, data width (PWDATA, PRDATA, cmd_wdata, rsp_rdata)
- TIMEOUT, 16, max ACCESS cycles with PREADY=0 before abort; 0 disables timeout
---
- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  bridge can accept command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes and on error)
- rsp_err  out  1  1 = transfer aborted by timeout
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB slave ready

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs registered except cmd_ready/rsp_valid (decoded from state).
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, set PSEL=1, PENABLE=0 -> SETUP.
- SETUP: exactly one cycle; set PENABLE=1 -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1, PADDR/PWRITE/PWDATA stable.
  - PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA, rsp_err=0, PSEL=PENABLE=0 -> RESP.
  - PREADY=0: increment wait counter; if TIMEOUT!=0 and counter reaches TIMEOUT, set rsp_rdata=0, rsp_err=1, PSEL=PENABLE=0 -> RESP.
  - Wait counter cleared on entry to SETUP; width $clog2(TIMEOUT+1), saturating, no wrap.
- RESP: rsp_valid=1, rsp_rdata/rsp_err held. On rsp_ready -> IDLE. cmd_ready=0 (no new command until response taken).
- PADDR/PWRITE/PWDATA hold last values in IDLE/RESP; only change on command acceptance.
- Exactly one response per accepted command, in order; no outstanding-transfer overlap.

## Timing
- Reset (async assert, sync-deassert expected externally): state=IDLE; PSEL, PENABLE, PWRITE=0; PADDR, PWDATA, rsp_rdata=0; rsp_err=0; rsp_valid=0; cmd_ready=1 after reset released.
- Zero-wait transfer: accept at edge N; SETUP cycle N+1; ACCESS N+2 (PREADY sampled at edge N+3); rsp_valid high N+3. Command-to-response latency 3 cycles.
- Each PREADY=0 ACCESS cycle adds one cycle; timeout response appears TIMEOUT cycles after first ACCESS cycle, +1.
- rsp_ready held high in RESP: IDLE next cycle; next command accepted at the earliest 1 cycle after response handshake (min 4-cycle issue interval).
- cmd_valid high outside IDLE: ignored, must remain stable (standard valid/ready).
- PRESETn asserted mid-transfer: PSEL/PENABLE drop immediately (async), pending command and response discarded, no rsp_valid.
- PREADY/PRDATA outside ACCESS: ignored.

## Structure
- Package apb_pkg: state enum (IDLE, SETUP, ACCESS, RESP, 2-bit), default ADDR_W/DATA_W constants, shared with the APB slave.
- Sub-module apb_wait_timer: clear/enable/saturating counter with timeout pulse, parameter TIMEOUT; instantiated once.

## Test plan
- Reset: assert PRESETn=0 mid-ACCESS -> all APB outputs 0 same cycle, rsp_valid=0, cmd_ready=1 after release.
- Write 0xDEADBEEF to addr 0x10, PREADY=1 -> PSEL rises N+1, PENABLE N+2, PWRITE=1, PADDR=0x10; rsp_valid N+3, rsp_err=0, rsp_rdata=0.
- Read addr 0x10 from slave model -> rsp_rdata=0xDEADBEEF, rsp_err=0, latency 3.
- Read with PREADY=0 for 3 ACCESS cycles -> PADDR/PSEL/PENABLE stable throughout, response 6 cycles after acceptance.
- PREADY stuck 0, TIMEOUT=16 -> rsp_err=1, rsp_rdata=0, PSEL=0 after 16 ACCESS cycles; next command proceeds normally.
- Backpressure: rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp held stable, cmd_ready=0, no PSEL until handshake.
